// File: rtl/ubfly_pkg.sv
// ---------------------------------------------------------------------------
// ubfly_pkg
// Shared definitions for the unary butterfly sequencing controller.
//   - ubfly_state_e  : controller state encoding (IDLE, LOAD, RUN, DONE)
//   - PERIOD         : bitstream period for the default BITWIDTH
//   - period_of()    : bitstream period 2^bw for any width
//   - runcnt_w()     : run-counter width, clog2(PERIOD+LAT+1)
//   - bipolar_offset(): raw count that encodes the value zero
// No ports (package).
// ---------------------------------------------------------------------------
package ubfly_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ubfly_state_e;

    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_LAT      = 4;
    localparam int PERIOD       = 1 << DEF_BITWIDTH;
    localparam int BIPOLAR_OFS  = 1 << (DEF_BITWIDTH - 1);

    function automatic int period_of(input int bw);
        return 1 << bw;
    endfunction

    // Must hold every run index 0 .. period+lat-1 with headroom for the compare.
    function automatic int runcnt_w(input int bw, input int lat);
        return $clog2((1 << bw) + lat + 1);
    endfunction

    function automatic int bipolar_offset(input int bw);
        return 1 << (bw - 1);
    endfunction

endpackage

// File: rtl/ubfly_ctrl_if.sv
// ---------------------------------------------------------------------------
// ubfly_ctrl_if
// Binary-side handshakes of the butterfly controller, named from the
// controller's point of view.
//   Request : iStart (valid), oReady, iwReal/iwImg (twiddle pair)
//   Result  : oValid, iReady, oCntReal0/oCntImg0/oCntReal1/oCntImg1
// Modports:
//   master : the transform scheduler (drives requests, consumes results)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface ubfly_ctrl_if #(
    parameter int BITWIDTH = 8
);
    logic                iStart;
    logic                oReady;
    logic [BITWIDTH-1:0] iwReal;
    logic [BITWIDTH-1:0] iwImg;

    logic                oValid;
    logic                iReady;
    logic [BITWIDTH:0]   oCntReal0;
    logic [BITWIDTH:0]   oCntImg0;
    logic [BITWIDTH:0]   oCntReal1;
    logic [BITWIDTH:0]   oCntImg1;

    modport master (
        output iStart, iwReal, iwImg, iReady,
        input  oReady, oValid, oCntReal0, oCntImg0, oCntReal1, oCntImg1
    );

    modport slave (
        input  iStart, iwReal, iwImg, iReady,
        output oReady, oValid, oCntReal0, oCntImg0, oCntReal1, oCntImg1
    );

endinterface

// File: rtl/ubfly_bitcnt.sv
// ---------------------------------------------------------------------------
// ubfly_bitcnt
// BITWIDTH+1-bit ones counter for one butterfly output bitstream.
//   iClk  : clock
//   iRst  : asynchronous active-high reset, clears the count
//   iClr  : synchronous clear (new transaction accepted)
//   iEn   : counting window enable
//   iBit  : bitstream input, counted when 1 inside the window
//   oCnt  : current count, 0 .. 2^BITWIDTH
// ---------------------------------------------------------------------------
module ubfly_bitcnt #(
    parameter int BITWIDTH = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClr,
    input  logic              iEn,
    input  logic              iBit,
    output logic [BITWIDTH:0] oCnt
);

    logic [BITWIDTH:0] cnt_q;
    logic [BITWIDTH:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn && iBit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCnt = cnt_q;

endmodule

// File: rtl/ubfly_ctrl.sv
// ---------------------------------------------------------------------------
// ubfly_ctrl
// Sequencing controller for one unary butterfly. Accepts a twiddle pair,
// strobes loadB/iClr for one cycle, enables the stream generators for one
// bitstream period, waits LAT flush cycles, counts ones on the four butterfly
// outputs over exactly one period, and returns the counts.
//
// Ports:
//   iClk, iRst        : clock, asynchronous active-high reset
//   bus (slave)       : request and result handshakes (see ubfly_ctrl_if)
//   owReal, owImg     : registered twiddle pair to the butterfly
//   oLoadB, oClr      : one-cycle load / clear strobes to the butterfly
//   oRun              : stream generator enable
//   iReal0..iImg1     : butterfly output bitstreams
//
// Build option UBFLY_CTRL_SIGNED_EN: when defined the counts are returned as
// two's-complement values (count - 2^(BITWIDTH-1)); otherwise raw counts.
// ---------------------------------------------------------------------------
module ubfly_ctrl
    import ubfly_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int LAT      = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    ubfly_ctrl_if.slave         bus,
    output logic [BITWIDTH-1:0] owReal,
    output logic [BITWIDTH-1:0] owImg,
    output logic                oLoadB,
    output logic                oClr,
    output logic                oRun,
    input  logic                iReal0,
    input  logic                iImg0,
    input  logic                iReal1,
    input  logic                iImg1
);

    localparam int P  = period_of(BITWIDTH);
    localparam int RW = runcnt_w(BITWIDTH, LAT);

    localparam logic [RW-1:0] R_LAST = RW'(P + LAT - 1);
    localparam logic [RW-1:0] R_WIN  = RW'(LAT);
    localparam logic [RW-1:0] R_PER  = RW'(P);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]          state_q, state_d;
    logic [RW-1:0]       r_q, r_d;
    logic                ready_q, loadb_q, run_q, valid_q;
    logic [BITWIDTH-1:0] wreal_q, wimg_q;

    logic                accept;
    logic                cnt_en;
    logic [3:0]          bits;
    logic [BITWIDTH:0]   raw [4];

    assign accept = (state_q == S_IDLE) && bus.iStart;

    // Outputs reach the butterfly LAT cycles after the stream bits that made
    // them, so the window opens at r = LAT. Its upper end (LAT + P) is never
    // reached because RUN ends at r = LAT + P - 1.
    assign cnt_en = (state_q == S_RUN) && (r_q >= R_WIN);

    assign bits = {iImg1, iReal1, iImg0, iReal0};

    // Next-state and run-counter logic.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
                    state_d = S_LOAD;
                    r_d     = '0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                r_d     = '0;
            end
            S_RUN: begin
                if (r_q == R_LAST) begin
                    state_d = S_DONE;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.iReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase
    end

    // Status and strobe flags are registered from the next state so every
    // output comes straight from a flop.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            ready_q <= 1'b1;
            loadb_q <= 1'b0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            wreal_q <= '0;
            wimg_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ready_q <= (state_d == S_IDLE);
            loadb_q <= (state_d == S_LOAD);
            run_q   <= (state_d == S_RUN) && (r_d < R_PER);
            valid_q <= (state_d == S_DONE);
            if (accept) begin
                wreal_q <= bus.iwReal;
                wimg_q  <= bus.iwImg;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        ubfly_bitcnt #(
            .BITWIDTH (BITWIDTH)
        ) u_cnt (
            .iClk (iClk),
            .iRst (iRst),
            .iClr (accept),
            .iEn  (cnt_en),
            .iBit (bits[g]),
            .oCnt (raw[g])
        );
    end

`ifdef UBFLY_CTRL_SIGNED_EN
    localparam logic signed [BITWIDTH:0] OFS_S = (BITWIDTH+1)'(bipolar_offset(BITWIDTH));

    logic signed [BITWIDTH:0] sres_q [4];
    logic                     to_done;

    // The last window bit is counted on the same edge that enters DONE, so
    // the offset is applied to the counter's next value, not its current one.
    assign to_done = (state_q == S_RUN) && (state_d == S_DONE);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < 4; i++) begin
                sres_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 4; i++) begin
                sres_q[i] <= '0;
            end
        end else if (to_done) begin
            for (int i = 0; i < 4; i++) begin
                sres_q[i] <= $signed(raw[i] + {{BITWIDTH{1'b0}}, (cnt_en & bits[i])}) - OFS_S;
            end
        end
    end

    assign bus.oCntReal0 = $unsigned(sres_q[0]);
    assign bus.oCntImg0  = $unsigned(sres_q[1]);
    assign bus.oCntReal1 = $unsigned(sres_q[2]);
    assign bus.oCntImg1  = $unsigned(sres_q[3]);
`else
    assign bus.oCntReal0 = raw[0];
    assign bus.oCntImg0  = raw[1];
    assign bus.oCntReal1 = raw[2];
    assign bus.oCntImg1  = raw[3];
`endif

    assign bus.oReady = ready_q;
    assign bus.oValid = valid_q;
    assign owReal     = wreal_q;
    assign owImg      = wimg_q;
    assign oLoadB     = loadb_q;
    assign oClr       = loadb_q;
    assign oRun       = run_q;

endmodule

// File: tb/tb_ubfly_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ubfly_ctrl
// Directed bench for ubfly_ctrl (BITWIDTH=8, LAT=4). Sample index k counts
// clock edges after the accepting edge: k=0 is LOAD, k=1..260 is RUN with
// r = k-1, k=261 is DONE. A stream bit driven at sample k is counted when
// 5 <= k <= 260.
// ---------------------------------------------------------------------------
module tb_ubfly_ctrl;
    import ubfly_pkg::*;

    localparam int BW  = 8;
    localparam int LAT = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;

    always #5 clk = clk_en ? ~clk : clk;

    ubfly_ctrl_if #(.BITWIDTH(BW)) bus ();

    logic [BW-1:0] owReal, owImg;
    logic          loadb, clr, run;
    logic          r0 = 1'b0, i0 = 1'b0, r1 = 1'b0, i1 = 1'b0;

    ubfly_ctrl #(
        .BITWIDTH (BW),
        .LAT      (LAT)
    ) dut (
        .iClk   (clk),
        .iRst   (rst),
        .bus    (bus),
        .owReal (owReal),
        .owImg  (owImg),
        .oLoadB (loadb),
        .oClr   (clr),
        .oRun   (run),
        .iReal0 (r0),
        .iImg0  (i0),
        .iReal1 (r1),
        .iImg1  (i1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Expected count output for a given raw ones count.
    function automatic logic [31:0] ecnt(input int raw);
        logic [BW:0] v;
`ifdef UBFLY_CTRL_SIGNED_EN
        v = (BW+1)'(raw - 128);
`else
        v = (BW+1)'(raw);
`endif
        return 32'(v);
    endfunction

    task automatic drive(input int mode, input int k);
        case (mode)
            0: begin
                r0 = 1'b1; i0 = 1'b0; r1 = 1'b0; i1 = 1'b0;
            end
            1: begin
                r0 = 1'b0;
                i0 = (k >= 5 && k <= 104);
                r1 = (k >= 1 && k <= 4);
                i1 = k[0];
            end
            2: begin
                r0 = (k % 4 == 0);
                i0 = (k >= 258 && k <= 265);
                r1 = 1'b1;
                i1 = 1'b0;
            end
            default: begin
                r0 = 1'b0; i0 = 1'b0; r1 = 1'b0; i1 = 1'b0;
            end
        endcase
    endtask

    task automatic do_accept(input logic [BW-1:0] wr, input logic [BW-1:0] wi, input logic hold);
        int n = 0;
        while (!bus.oReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("acc_ready", 32'(bus.oReady), 1);
        bus.iwReal = wr;
        bus.iwImg  = wi;
        bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = hold;
        chk("tw_real", 32'(owReal), 32'(wr));
        chk("tw_img", 32'(owImg), 32'(wi));
    endtask

    int vk, runs, loads, clrs, lk, rdy;

    task automatic run_txn(input int mode, input logic start_lvl);
        vk = -1; runs = 0; loads = 0; clrs = 0; lk = -1; rdy = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.oValid) begin
                vk = k;
                break;
            end
            if (loadb) begin loads++; lk = k; end
            if (clr) clrs++;
            if (run) runs++;
            if (bus.oReady) rdy++;
            drive(mode, k);
            bus.iStart = start_lvl;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_counts(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_r0"}, 32'(bus.oCntReal0), ecnt(e0));
        chk({tag, "_i0"}, 32'(bus.oCntImg0), ecnt(e1));
        chk({tag, "_r1"}, 32'(bus.oCntReal1), ecnt(e2));
        chk({tag, "_i1"}, 32'(bus.oCntImg1), ecnt(e3));
    endtask

    logic [BW:0] s0, s1, s2, s3;
    logic        stable;
    int          vseen;

    initial begin
        bus.iStart = 1'b0;
        bus.iReady = 1'b0;
        bus.iwReal = '0;
        bus.iwImg  = '0;

        // Reset with the clock stopped.
        #3 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.oReady), 1);
        chk("rst_valid", 32'(bus.oValid), 0);
        chk("rst_strobes", 32'({loadb, clr, run}), 0);
        chk("rst_tw", 32'({owReal, owImg}), 0);
        chk("rst_cnt", 32'({bus.oCntReal0, bus.oCntImg0, bus.oCntReal1, bus.oCntImg1}), 0);
        #2 rst = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Saturated iReal0, other streams idle, results taken immediately.
        bus.iReady = 1'b1;
        do_accept(8'h80, 8'h3C, 1'b0);
        run_txn(0, 1'b0);
        chk("a_vlat", 32'(vk), 261);
        chk("a_loads", 32'(loads), 1);
        chk("a_load_k", 32'(lk), 0);
        chk("a_clrs", 32'(clrs), 1);
        chk("a_runs", 32'(runs), 256);
        chk("a_rdy_busy", 32'(rdy), 0);
        chk_counts("a", 256, 0, 0, 0);
        @(posedge clk); #1;
        chk("a_exit_valid", 32'(bus.oValid), 0);
        chk("a_exit_ready", 32'(bus.oReady), 1);
        chk("a_held_r0", 32'(bus.oCntReal0), ecnt(256));

        // Alternating / windowed streams, backpressure, start ignored while busy.
        bus.iReady = 1'b0;
        do_accept(8'h5A, 8'hA5, 1'b0);
        bus.iwReal = 8'h11;
        bus.iwImg  = 8'h22;
        run_txn(1, 1'b1);
        chk("b_vlat", 32'(vk), 261);
        chk("b_rdy_busy", 32'(rdy), 0);
        chk_counts("b", 0, 100, 0, 128);
        s0 = bus.oCntReal0; s1 = bus.oCntImg0; s2 = bus.oCntReal1; s3 = bus.oCntImg1;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive(1, c);
            @(posedge clk); #1;
            if (!bus.oValid || bus.oReady || owReal != 8'h5A || owImg != 8'hA5 ||
                bus.oCntReal0 != s0 || bus.oCntImg0 != s1 ||
                bus.oCntReal1 != s2 || bus.oCntImg1 != s3) stable = 1'b0;
        end
        chk("b_bp_stable", 32'(stable), 1);
        bus.iStart = 1'b0;
        bus.iReady = 1'b1;
        @(posedge clk); #1;
        chk("b_rel_valid", 32'(bus.oValid), 0);
        chk("b_rel_ready", 32'(bus.oReady), 1);

        // Back-to-back with iStart and iReady held high.
        do_accept(8'h21, 8'h12, 1'b1);
        run_txn(0, 1'b1);
        chk("c1_vlat", 32'(vk), 261);
        chk_counts("c1", 256, 0, 0, 0);
        bus.iwReal = 8'h42;
        bus.iwImg  = 8'h24;
        @(posedge clk); #1;
        chk("c_idle_ready", 32'(bus.oReady), 1);
        chk("c_idle_valid", 32'(bus.oValid), 0);
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        chk("c2_tw_real", 32'(owReal), 32'h42);
        chk("c2_tw_img", 32'(owImg), 32'h24);
        chk("c2_load", 32'(loadb), 1);
        chk("c2_cnt_zero", 32'({bus.oCntReal0, bus.oCntImg0, bus.oCntReal1, bus.oCntImg1}), 0);
        run_txn(2, 1'b0);
        chk("c2_vlat", 32'(vk), 261);
        chk_counts("c2", 64, 3, 256, 0);
        @(posedge clk); #1;

        // Reset in the middle of RUN at r = 100.
        do_accept(8'h77, 8'h88, 1'b0);
        for (int k = 0; k <= 100; k++) begin
            drive(0, k);
            @(posedge clk); #1;
        end
        chk("d_running", 32'(run), 1);
        rst = 1'b1;
        #1;
        chk("d_rst_ready", 32'(bus.oReady), 1);
        chk("d_rst_out", 32'({loadb, clr, run, bus.oValid}), 0);
        chk("d_rst_tw", 32'({owReal, owImg}), 0);
        chk("d_rst_cnt", 32'({bus.oCntReal0, bus.oCntImg0, bus.oCntReal1, bus.oCntImg1}), 0);
        #1 rst = 1'b0;
        drive(3, 0);
        vseen = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (bus.oValid || !bus.oReady) vseen++;
        end
        chk("d_no_valid", 32'(vseen), 0);
        do_accept(8'h99, 8'h66, 1'b0);
        run_txn(1, 1'b0);
        chk("d_vlat", 32'(vk), 261);
        chk_counts("d", 0, 100, 0, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
